if_fetch: RTL and testbench
===========================

# if_fetch

Instruction-fetch stage of the MIPS32 pipeline: owns the program counter, drives the instruction-ROM request/ready bus, and presents `addr_out`/`inst_out` to the IF/ID pipeline register. It applies branch redirects from ID (delay-slot semantics) and exception redirects from the pipeline controller. It raises a stall request while a ROM access is outstanding, and it buffers a returned word while the stage is stalled.

## Interface
- `RESET_PC`, default 32'hBFC0_0000: PC loaded on reset (MIPS reset vector).
- `clk`  in  1: pipeline clock.
- `rst`  in  1: reset; synchronous, active-high.
- `stall_current_stage`  in  1: controller stall for IF; hold PC and outputs.
- `flush`  in  1: exception flush; highest priority.
- `exc_pc`  in  `ADDR_BUS`: exception/ERET target, valid with `flush`.
- `branch_flag`  in  1: taken branch/jump resolved in ID.
- `branch_addr`  in  `ADDR_BUS`: branch target, valid with `branch_flag`.
- `rom_en`  out  1: ROM request.
- `rom_addr`  out  `ADDR_BUS`: ROM word address.
- `rom_ready`  in  1: ROM response; the beat completes when `rom_en && rom_ready`.
- `rom_rdata`  in  `INST_BUS`: ROM data, valid on the completing beat.
- `stall_request`  out  1: to the controller; the fetch is not yet complete.
- `addr_out`  out  `ADDR_BUS`: PC of the presented instruction, to IF/ID.
- `inst_out`  out  `INST_BUS`: presented instruction, to IF/ID; 0 (NOP) when none.

## Operation
- FSM states:
  - RESET: one cycle after `rst`.
  - RUN: normal fetch.
  - DRAIN: an abandoned request is waiting for `rom_ready`.
- `rst` response:
  - `pc=RESET_PC`; `buf_valid=0`; `redir_pending=0`.
  - State goes to RESET.
  - All outputs 0.
- RESET → RUN unconditionally. `rom_en=0` in RESET.
- RUN, request:
  - `rom_en=1` and `rom_addr=pc`, unless `buf_valid`.
  - Address and enable stay stable until the beat completes.
- RUN, beat completes:
  - `inst_out=rom_rdata`, `addr_out=pc`, combinationally, same cycle.
  - If `stall_current_stage`: capture the word into `inst_buf`, set `buf_valid=1`, hold `pc`.
  - Otherwise: advance `pc`.
- `buf_valid=1`:
  - `inst_out=inst_buf`, `addr_out=pc`, `rom_en=0`.
  - On the first cycle with `!stall_current_stage`: clear `buf_valid` and advance `pc`.
- No instruction available: `inst_out=0`, `addr_out=pc`.
- `stall_request = rom_en && !rom_ready`.
- PC advance uses `next = redir_pending ? redir_addr : pc+4`, then clears `redir_pending`.
- `branch_flag` latches `redir_pending=1`, `redir_addr=branch_addr`.
  - This happens on any cycle, stalled or not.
  - The current IF word is the delay slot, so it is not squashed.
- `flush` (priority over branch and over stall):
  - `buf_valid=0`, `redir_pending=0`, `pc=exc_pc`.
  - `inst_out=0` in the `flush` cycle.
  - If a request is outstanding and incomplete in the `flush` cycle, state goes to DRAIN.
- DRAIN:
  - Keep `rom_en=1` with the old `rom_addr`.
  - On `rom_ready`: discard the data, go to RUN.
  - `inst_out=0`; `stall_request` stays as defined above.
  - A second `flush` in DRAIN updates `pc` only.
- Addresses: `rom_addr[1:0]` is forced to 2'b00. Targets are word-aligned by contract; bits [1:0] are ignored.
- `pc+4` wraps modulo 2^32.

## Timing
- Zero-wait ROM (`rom_ready` high in the cycle `rom_en` rises): one instruction per cycle, 0-cycle fetch latency to `inst_out`. IF/ID captures it at the next edge.
- N-wait ROM: `stall_request` is high for N cycles, and the word appears in cycle N+1 after the request.
- Branch asserted in cycle t with the delay slot completing in t: the target is requested in t+1.
- Branch asserted while the delay slot is still waiting: the target is requested the cycle after that beat completes.
- Flush in cycle t with no outstanding request: `exc_pc` is requested in t+1.
- Flush in cycle t with an outstanding request: `exc_pc` is requested the cycle after the drained beat.
- `stall_current_stage` and beat completion in the same cycle: the word is buffered, no refetch.
- Reset mid-transaction: `rom_en` drops immediately. The ROM treats `rst` as abort.

## Structure
- Shared include `bus.v`:
  - `ADDR_BUS`, `ADDR_BUS_WIDTH`, `INST_BUS`, `INST_BUS_WIDTH` (32).
  - Add `RESET_PC_DEFAULT` and the `IF_STATE_*` encodings (2-bit).
- One natural sub-module: `pc_reg`.
  - Contents: PC, `redir_pending`/`redir_addr` and next-PC selection.
  - The FSM and hold buffer stay in `if_fetch`.

## Test plan
- Reset, zero-wait ROM returning `addr>>2`: `rom_addr` goes BFC00000, 04, 08…; `inst_out` equals `rom_addr>>2` each cycle; `stall_request` stays 0.
- Two-wait ROM: `stall_request` is high for 2 cycles per fetch; `addr_out`/`inst_out` appear only on the ready beat.
- `branch_flag` with `branch_addr`=BFC00100 while fetching BFC00008: BFC00008 (delay slot) is presented, then BFC00100.
- `stall_current_stage` held 3 cycles while a beat completes: one ROM beat only; `inst_out` is stable for 4 cycles; `pc` advances when the stall releases.
- `flush` with `exc_pc`=BFC00380 during a 3-wait request: `rom_addr` holds the old address until ready; that data is discarded (`inst_out=0`); next request is BFC00380.
- `rst` asserted mid-wait: the next cycle shows `rom_en=0` and all outputs 0; the first request after the RESET cycle is BFC00000.

Source files
------------

// File: rtl/if_fetch_pkg.sv
// if_fetch shared types: bus widths, reset vector, FSM encoding.
// Imported by the fetch stage, its PC register and the ROM bus interface.
package if_fetch_pkg;

  localparam int ADDR_BUS_WIDTH = 32;
  localparam int INST_BUS_WIDTH = 32;

  typedef logic [ADDR_BUS_WIDTH-1:0] addr_t;
  typedef logic [INST_BUS_WIDTH-1:0] inst_t;

  localparam addr_t RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam addr_t PC_STEP          = 32'd4;
  localparam addr_t WORD_MASK        = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    IF_STATE_RESET = 2'd0,
    IF_STATE_RUN   = 2'd1,
    IF_STATE_DRAIN = 2'd2
  } if_state_e;

  // Targets are word aligned; low bits are ignored.
  function automatic addr_t word_align(addr_t a);
    return a & WORD_MASK;
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// Instruction ROM request/ready bus.
// master = fetch stage, slave = instruction ROM.
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic  rom_en;
  addr_t rom_addr;
  logic  rom_ready;
  inst_t rom_rdata;

  modport master (
    output rom_en,
    output rom_addr,
    input  rom_ready,
    input  rom_rdata
  );

  modport slave (
    input  rom_en,
    input  rom_addr,
    output rom_ready,
    output rom_rdata
  );

endinterface

// File: rtl/if_fetch_pc_reg.sv
// Program counter with latched branch redirect.
// A taken branch waits until its delay slot leaves IF.
module if_fetch_pc_reg
  import if_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  flush_i,
  input  addr_t exc_pc_i,
  input  logic  branch_flag_i,
  input  addr_t branch_addr_i,
  input  logic  advance_i,
  output addr_t pc_o
);

  addr_t pc_q, pc_d;
  logic  redir_pending_q, redir_pending_d;
  addr_t redir_addr_q, redir_addr_d;

  assign pc_o = pc_q;

  // Next PC: flush wins, then advance, else latch a branch.
  always_comb begin
    pc_d            = pc_q;
    redir_pending_d = redir_pending_q;
    redir_addr_d    = redir_addr_q;
    if (flush_i) begin
      pc_d            = word_align(exc_pc_i);
      redir_pending_d = 1'b0;
    end else if (advance_i) begin
      if (branch_flag_i) begin
        pc_d = word_align(branch_addr_i);
      end else if (redir_pending_q) begin
        pc_d = redir_addr_q;
      end else begin
        pc_d = pc_q + PC_STEP;
      end
      redir_pending_d = 1'b0;
    end else if (branch_flag_i) begin
      redir_pending_d = 1'b1;
      redir_addr_d    = word_align(branch_addr_i);
    end
  end

  // PC and redirect state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q            <= word_align(RESET_PC);
      redir_pending_q <= 1'b0;
      redir_addr_q    <= '0;
    end else begin
      pc_q            <= pc_d;
      redir_pending_q <= redir_pending_d;
      redir_addr_q    <= redir_addr_d;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// MIPS32 instruction-fetch stage: ROM handshake, hold buffer,
// flush drain and presentation of the word to IF/ID.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter addr_t RESET_PC = RESET_PC_DEFAULT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       stall_current_stage,
  input  logic       flush,
  input  addr_t      exc_pc,
  input  logic       branch_flag,
  input  addr_t      branch_addr,
  if_fetch_if.master rom,
  output logic       stall_request,
  output addr_t      addr_out,
  output inst_t      inst_out
);

  if_state_e state_q, state_d;
  logic      buf_valid_q, buf_valid_d;
  inst_t     inst_buf_q, inst_buf_d;
  addr_t     drain_addr_q, drain_addr_d;

  addr_t pc;
  logic  advance;
  logic  rom_en_c;
  addr_t rom_addr_c;
  inst_t inst_c;
  addr_t addr_c;

  if_fetch_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk           (clk),
    .rst           (rst),
    .flush_i       (flush),
    .exc_pc_i      (exc_pc),
    .branch_flag_i (branch_flag),
    .branch_addr_i (branch_addr),
    .advance_i     (advance),
    .pc_o          (pc)
  );

  // Reset aborts the bus in the same cycle.
  assign rom.rom_en     = rom_en_c & ~rst;
  assign rom.rom_addr   = rst ? '0 : rom_addr_c;
  assign inst_out       = rst ? '0 : inst_c;
  assign addr_out       = rst ? '0 : addr_c;
  assign stall_request  = rom.rom_en & ~rom.rom_ready;

  // FSM next state, bus request and presented word.
  always_comb begin
    state_d      = state_q;
    buf_valid_d  = buf_valid_q;
    inst_buf_d   = inst_buf_q;
    drain_addr_d = drain_addr_q;
    advance      = 1'b0;
    rom_en_c     = 1'b0;
    rom_addr_c   = '0;
    inst_c       = '0;
    addr_c       = '0;
    unique case (state_q)
      IF_STATE_RESET: begin
        state_d = IF_STATE_RUN;
      end
      IF_STATE_RUN: begin
        addr_c = pc;
        if (buf_valid_q) begin
          inst_c = inst_buf_q;
          if (!stall_current_stage) begin
            buf_valid_d = 1'b0;
            advance     = 1'b1;
          end
        end else begin
          rom_en_c   = 1'b1;
          rom_addr_c = pc;
          if (rom.rom_ready) begin
            inst_c = rom.rom_rdata;
            if (stall_current_stage) begin
              buf_valid_d = 1'b1;
              inst_buf_d  = rom.rom_rdata;
            end else begin
              advance = 1'b1;
            end
          end
        end
        if (flush) begin
          inst_c      = '0;
          buf_valid_d = 1'b0;
          advance     = 1'b0;
          if (rom_en_c && !rom.rom_ready) begin
            state_d      = IF_STATE_DRAIN;
            drain_addr_d = rom_addr_c;
          end
        end
      end
      IF_STATE_DRAIN: begin
        rom_en_c   = 1'b1;
        rom_addr_c = drain_addr_q;
        addr_c     = pc;
        if (rom.rom_ready) begin
          state_d = IF_STATE_RUN;
        end
      end
      default: begin
        state_d = IF_STATE_RESET;
      end
    endcase
  end

  // State, hold buffer and drain address registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IF_STATE_RESET;
      buf_valid_q  <= 1'b0;
      inst_buf_q   <= '0;
      drain_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      buf_valid_q  <= buf_valid_d;
      inst_buf_q   <= inst_buf_d;
      drain_addr_q <= drain_addr_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: wait-state ROM, random
// stall/branch/flush/reset, program-order scoreboard.
module tb_if_fetch;
  import if_fetch_pkg::*;

  localparam addr_t RPC = 32'hBFC0_0000;
  localparam addr_t EXC = 32'hBFC0_0380;

  logic  clk = 1'b0;
  logic  rst = 1'b1;
  logic  stall = 1'b0;
  logic  flush = 1'b0;
  logic  branch_flag = 1'b0;
  addr_t exc_pc = '0;
  addr_t branch_addr = '0;
  logic  stall_request;
  addr_t addr_out;
  inst_t inst_out;

  if_fetch_if rom();

  int wait_n = 0;
  int wcnt = 0;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(RPC)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .stall_current_stage (stall),
    .flush               (flush),
    .exc_pc              (exc_pc),
    .branch_flag         (branch_flag),
    .branch_addr         (branch_addr),
    .rom                 (rom),
    .stall_request       (stall_request),
    .addr_out            (addr_out),
    .inst_out            (inst_out)
  );

  // ROM contents: never zero, identifies the word address.
  function automatic inst_t rom_word(addr_t a);
    return {2'b11, a[31:2]};
  endfunction

  assign rom.rom_ready = rom.rom_en && (wcnt >= wait_n);
  assign rom.rom_rdata = rom_word(rom.rom_addr);

  always @(posedge clk) begin
    if (rst || !rom.rom_en || rom.rom_ready) wcnt <= 0;
    else wcnt <= wcnt + 1;
  end

  int checks = 0;
  int failures = 0;
  int acc_cnt = 0;
  int beat_cnt = 0;
  int sreq_cnt = 0;
  addr_t exp_q[$];
  logic  pend = 1'b0;
  addr_t pend_addr = '0;
  int    age = 0;
  logic  flush_a1 = 1'b0;
  logic  prev_wait = 1'b0;
  addr_t prev_addr = '0;
  logic  lb_v = 1'b0;
  addr_t lb_a = '0;
  int    idle = 0;
  logic  saw_zero = 1'b0;
  addr_t e_m, nx_m;

  task automatic chk(input bit ok, input string name,
                     input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  // Monitor: protocol checks and program-order scoreboard.
  always @(negedge clk) begin
    chk(stall_request == (rom.rom_en && !rom.rom_ready), "stall_req",
        {31'b0, stall_request}, {31'b0, rom.rom_en && !rom.rom_ready});
    if (stall_request) sreq_cnt++;
    if (rst) begin
      exp_q.delete();
      exp_q.push_back(RPC);
      pend = 1'b0;
      age = 0;
      lb_v = 1'b0;
      idle = 0;
      prev_wait = 1'b0;
    end else begin
      if (age < 3) age++;
      if (age == 1) begin
        chk(!rom.rom_en, "reset_rom_en", {31'b0, rom.rom_en}, 0);
        chk(addr_out == 0, "reset_addr_out", addr_out, 0);
        chk(inst_out == 0, "reset_inst_out", inst_out, 0);
        flush_a1 = flush;
      end
      if (age == 2 && !flush_a1)
        chk(rom.rom_en && rom.rom_addr == RPC, "first_req", rom.rom_addr, RPC);
      if (prev_wait)
        chk(rom.rom_en && rom.rom_addr == prev_addr, "addr_hold",
            rom.rom_addr, prev_addr);
      if (rom.rom_en) begin
        e_m = rom.rom_addr & 32'h3;
        chk(e_m == 0, "addr_align", rom.rom_addr, rom.rom_addr & WORD_MASK);
      end
      if (rom.rom_en && rom.rom_ready) begin
        beat_cnt++;
        chk(!(lb_v && lb_a == rom.rom_addr), "dup_beat", rom.rom_addr, lb_a);
        lb_v = 1'b1;
        lb_a = rom.rom_addr;
      end
      if (flush) begin
        chk(inst_out == 0, "flush_nop", inst_out, 0);
        exp_q.delete();
        exp_q.push_back(exc_pc & WORD_MASK);
        pend = 1'b0;
        idle = 0;
      end else if (inst_out != 0 && !stall) begin
        acc_cnt++;
        idle = 0;
        if (exp_q.size() == 0) begin
          chk(1'b0, "queue_empty", addr_out, 0);
        end else begin
          e_m = exp_q.pop_front();
          chk(addr_out == e_m, "accept_addr", addr_out, e_m);
          chk(inst_out == rom_word(e_m), "accept_inst", inst_out, rom_word(e_m));
          if (e_m == 0) saw_zero = 1'b1;
          if (branch_flag) nx_m = branch_addr & WORD_MASK;
          else if (pend) nx_m = pend_addr;
          else nx_m = e_m + 32'd4;
          exp_q.push_back(nx_m);
          pend = 1'b0;
        end
      end else begin
        if (branch_flag) begin
          pend = 1'b1;
          pend_addr = branch_addr & WORD_MASK;
        end
        if (!stall) idle++;
        if (idle > 40) begin
          chk(1'b0, "progress", idle, 40);
          idle = 0;
        end
      end
      prev_wait = rom.rom_en && !rom.rom_ready;
      prev_addr = rom.rom_addr;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    branch_flag = 1'b0;
    cyc();
    rst = 1'b0;
  endtask

  int c0, s0, b0, n, bcnt, fcnt;
  logic found;
  inst_t i0;
  addr_t a0;

  initial begin
    #1_000_000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    bcnt = 0;
    fcnt = 0;
    // zero-wait stream
    wait_n = 0;
    do_reset();
    cyc();
    c0 = acc_cnt;
    repeat (20) cyc();
    chk(acc_cnt - c0 == 20, "zero_wait_rate", acc_cnt - c0, 20);

    // two-wait ROM
    wait_n = 2;
    do_reset();
    cyc();
    c0 = acc_cnt;
    s0 = sreq_cnt;
    repeat (30) cyc();
    chk(acc_cnt - c0 == 10, "two_wait_rate", acc_cnt - c0, 10);
    chk(sreq_cnt - s0 == 20, "two_wait_stall", sreq_cnt - s0, 20);

    // branch with delay slot at BFC00008
    wait_n = 0;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      cyc();
      if (rom.rom_addr == 32'hBFC0_0008) found = 1'b1;
    end
    chk(found, "find_delay_slot", {31'b0, found}, 1);
    branch_flag = 1'b1;
    branch_addr = 32'hBFC0_0100;
    cyc();
    branch_flag = 1'b0;
    samp();
    chk(rom.rom_addr == 32'hBFC0_0100, "branch_target", rom.rom_addr, 32'hBFC0_0100);

    // stall held over a completing beat
    cyc();
    stall = 1'b1;
    samp();
    i0 = inst_out;
    a0 = rom.rom_addr;
    b0 = beat_cnt;
    repeat (2) begin
      cyc();
      samp();
      chk(inst_out == i0, "stall_hold", inst_out, i0);
    end
    cyc();
    stall = 1'b0;
    samp();
    chk(inst_out == i0, "stall_release", inst_out, i0);
    chk(beat_cnt == b0, "one_beat", beat_cnt, b0);
    cyc();
    samp();
    chk(rom.rom_addr == a0 + 32'd4, "stall_advance", rom.rom_addr, a0 + 32'd4);

    // flush during a three-wait request
    wait_n = 3;
    do_reset();
    cyc();
    flush = 1'b1;
    exc_pc = EXC;
    cyc();
    flush = 1'b0;
    n = 0;
    for (int i = 1; i <= 10 && n == 0; i++) begin
      samp();
      if (rom.rom_en && rom.rom_addr == EXC) n = i;
      else chk(inst_out == 0, "drain_nop", inst_out, 0);
      if (n == 0) cyc();
    end
    chk(n == 4, "flush_latency", n, 4);

    // reset while a request is waiting
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (8) cyc();

    // PC wrap through 0
    wait_n = 0;
    do_reset();
    cyc();
    branch_flag = 1'b1;
    branch_addr = 32'hFFFF_FFF8;
    cyc();
    branch_flag = 1'b0;
    repeat (5) cyc();

    // random traffic
    for (int k = 0; k < 3000; k++) begin
      cyc();
      rst = ($urandom % 400) == 0;
      wait_n = $urandom % 4;
      stall = ($urandom % 4) == 0;
      flush = ($urandom % 40) == 0;
      if (flush) begin
        fcnt++;
        exc_pc = 32'hA000_0000 + (fcnt << 12) + ($urandom % 4);
      end
      branch_flag = ($urandom % 10) == 0;
      if (branch_flag) begin
        bcnt++;
        branch_addr = 32'h8000_0000 + (bcnt << 12) + ($urandom % 4);
      end
    end
    cyc();
    rst = 1'b0;
    stall = 1'b0;
    flush = 1'b0;
    branch_flag = 1'b0;
    repeat (20) cyc();

    chk(saw_zero, "wrap_seen", {31'b0, saw_zero}, 1);
    chk(acc_cnt > 300, "accept_volume", acc_cnt, 300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
